uart_tx_stream: RTL and testbench
=================================

# uart_tx_stream

Byte-stream-to-serial transmitter that consumes the valid/ready byte stream leaving the USB UART core (host→device direction) and drives it out as 8N1 asynchronous serial on a single pin. It sits between `usb_uart_np` `uart_out_*` and a board TX pin, and forms a USB-to-serial bridge. An internal buffer decouples USB bursts from the slow serial line.

## Interface
Parameters:
- `ClockHz`, 48000000: frequency of `clk_48mhz` in Hz.
- `BaudRate`, 115200: serial bit rate.
- `FifoDepthLog2`, 4: log2 of buffer depth. Used only when `UART_TX_FIFO_EN` is defined.

Ports:
- `clk_48mhz`  input  1  the only clock. All state changes on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `uart_in_data`  input  8  byte to transmit.
- `uart_in_valid`  input  1  source holds a byte.
- `uart_in_ready`  output  1  block accepts a byte this cycle.
- `pin_tx`  output  1  registered serial output. Idles high.
- `busy`  output  1  high while a frame is on the line or the buffer is non-empty.
- `level`  output  `FifoDepthLog2+1`  number of bytes buffered and not yet started.

## Operation
- Bit period `Divisor = (ClockHz + BaudRate/2) / BaudRate`, an integer computed at elaboration.
  - Elaboration fails if `Divisor < 2`.
  - Bit counter width is `$clog2(Divisor)`. The counter runs 0..Divisor-1 and wraps.
- Handshake:
  - A byte transfers on any rising edge where `uart_in_valid && uart_in_ready`.
  - `uart_in_ready` = buffer not full. It is combinational from buffer state only and never depends on `uart_in_valid`.
  - The source may change data freely while `uart_in_ready` is low.
- Frame format: start bit (0), 8 data bits LSB first, one stop bit (1). No parity.
- State machine states are IDLE, START, DATA, STOP.
  - IDLE: `pin_tx`=1. If the buffer is non-empty, pop one byte into the shift register, load the bit counter with 0, and go to START.
  - START: `pin_tx`=0 for Divisor cycles, then go to DATA with bit index 0.
  - DATA: `pin_tx`=shift[0] for Divisor cycles per bit. Shift right after each bit. After bit index 7, go to STOP.
  - STOP: `pin_tx`=1 for Divisor cycles. On the last cycle:
    - if the buffer is non-empty, pop and go directly to START, giving no idle gap;
    - otherwise go to IDLE.
- Buffer boundaries:
  - Push and pop in the same cycle is legal when the buffer is neither empty nor full, and `level` is unchanged.
  - A push into an empty buffer cannot be popped in the same cycle. It is popped on the next edge at the earliest.
  - No push occurs when full, because ready is low.
  - Pointers wrap modulo depth. `level` saturates at depth by construction.
- Reset, asserted at any time including mid-frame, takes effect immediately:
  - state IDLE, `pin_tx`=1, `busy`=0, `level`=0, buffer emptied;
  - `uart_in_ready`=0 while `reset` is high and 1 from the first cycle after release.
  - A truncated frame is not resumed.

## Timing
- A byte accepted at edge N into an empty, idle block is popped at edge N+1. `pin_tx` falls after edge N+1.
- Full frame is `10*Divisor` cycles. `pin_tx` rises for the stop bit `9*Divisor` cycles after the start edge.
- Back-to-back bytes give continuous frames. The next start bit begins on the cycle after the last stop-bit cycle.
- `busy` rises the cycle after the first accepted byte. It falls on the edge the FSM returns to IDLE with an empty buffer.
- `level` updates on the same edge as the push or pop.

## Configuration
- `UART_TX_FIFO_EN` defined:
  - the buffer is a `2**FifoDepthLog2`-entry circular FIFO;
  - `level` ranges 0..depth.
- `UART_TX_FIFO_EN` undefined:
  - the buffer is a single holding register (depth 1);
  - `FifoDepthLog2` is ignored;
  - `level` is 0 or 1 in its LSB, upper bits 0;
  - `uart_in_ready` = holding register empty.
- Serial timing and frame format are identical in both builds.

## Test plan
All scenarios use `ClockHz`=48000000 and `BaudRate`=12000000, so Divisor=4.
- Reset then idle 100 cycles -> `pin_tx`=1, `busy`=0, `level`=0, `uart_in_ready`=1 after release.
- Single byte 0x55 at edge N -> `pin_tx` falls after N+1. Sequence 0,1,0,1,0,1,0,1,0,1, each held 4 cycles (40 cycles total), then idle high, and `busy` drops.
- Three bytes 0x00, 0xFF, 0xA5 presented back-to-back -> 120 contiguous frame cycles with no idle gap. Decoded bytes match in order.
- With FIFO (depth 16), hold valid continuously with 20 bytes:
  - ready drops when `level` reaches 16;
  - ready reasserts one cycle after the first pop following full;
  - all 20 bytes are transmitted in order.
- Without FIFO, hold valid continuously -> ready deasserts after each accept and reasserts on the pop edge. The second frame's start immediately follows the first frame's stop.
- Assert `reset` mid-DATA of a 0x3C frame -> `pin_tx`=1 immediately, `level`=0. After release, a new byte 0x81 is sent as a clean complete frame.

Source files
------------

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: takes a valid/ready byte stream and sends it out as 8N1
// asynchronous serial (start 0, eight data bits LSB first, stop 1) on pin_tx.
// A buffer decouples bursty byte arrival from the slow serial line.
//
// Build option: define UART_TX_FIFO_EN to get a 2**FifoDepthLog2-entry
// circular FIFO. Without it the buffer is a single holding register and
// FifoDepthLog2 only sets the width of `level`.
//
// The bit period is Divisor = round(ClockHz / BaudRate) clocks. Divisor must be
// at least 2, otherwise elaboration stops.

module uart_tx_stream #(
  parameter int ClockHz       = 48000000,
  parameter int BaudRate      = 115200,
  parameter int FifoDepthLog2 = 4
) (
  input  logic                   clk_48mhz,
  input  logic                   reset,
  input  logic [7:0]             uart_in_data,
  input  logic                   uart_in_valid,
  output logic                   uart_in_ready,
  output logic                   pin_tx,
  output logic                   busy,
  output logic [FifoDepthLog2:0] level
);

  // ---------------------------------------------------------------------------
  // Bit timing
  // ---------------------------------------------------------------------------
  localparam int Divisor = (ClockHz + BaudRate / 2) / BaudRate;
  localparam int CntW    = (Divisor < 2) ? 1 : $clog2(Divisor);
  localparam logic [CntW-1:0] CntLast = CntW'(Divisor - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1'b1);
  localparam logic [CntW-1:0] CntZero = CntW'(1'b0);

  if (Divisor < 2) begin : g_divisor_check
    $error("uart_tx_stream: Divisor = (ClockHz + BaudRate/2) / BaudRate must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Buffer interface shared by both builds
  // ---------------------------------------------------------------------------
  logic       push;
  logic       pop;
  logic       buf_empty;
  logic       buf_full;
  logic       buf_nonempty_d;
  logic [7:0] pop_data;

  // Ready reflects buffer occupancy only (and is forced low during reset), so a
  // source never sees ready depend on its own valid.
  assign uart_in_ready = !reset && !buf_full;
  assign push          = uart_in_valid && uart_in_ready;

`ifdef UART_TX_FIFO_EN
  // ---------------------------------------------------------------------------
  // Circular FIFO, depth 2**FifoDepthLog2
  // ---------------------------------------------------------------------------
  localparam int Depth = 2 ** FifoDepthLog2;
  localparam logic [FifoDepthLog2:0]   FullCount = {1'b1, {FifoDepthLog2{1'b0}}};
  localparam logic [FifoDepthLog2:0]   CountZero = {(FifoDepthLog2 + 1){1'b0}};
  localparam logic [FifoDepthLog2:0]   CountOne  = (FifoDepthLog2 + 1)'(1'b1);
  localparam logic [FifoDepthLog2-1:0] PtrOne    = FifoDepthLog2'(1'b1);

  logic [7:0]               mem_q [Depth];
  logic [FifoDepthLog2-1:0] wr_ptr_q;
  logic [FifoDepthLog2-1:0] wr_ptr_d;
  logic [FifoDepthLog2-1:0] rd_ptr_q;
  logic [FifoDepthLog2-1:0] rd_ptr_d;
  logic [FifoDepthLog2:0]   count_q;
  logic [FifoDepthLog2:0]   count_d;

  assign buf_empty      = (count_q == CountZero);
  assign buf_full       = (count_q == FullCount);
  assign pop_data       = mem_q[rd_ptr_q];
  assign level          = count_q;
  assign buf_nonempty_d = (count_d != CountZero);

  // Next pointers and occupancy; a simultaneous push and pop leaves count as is
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CountOne;
      2'b01:   count_d = count_q - CountOne;
      default: count_d = count_q;
    endcase
  end

  // Storage array; no reset needed because occupancy gates every read
  always_ff @(posedge clk_48mhz) begin
    if (push) begin
      mem_q[wr_ptr_q] <= uart_in_data;
    end
  end

  // FIFO pointer and occupancy registers; reset empties the buffer
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= CountZero;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`else
  // ---------------------------------------------------------------------------
  // Single holding register (depth 1)
  // ---------------------------------------------------------------------------
  logic [7:0] hold_data_q;
  logic [7:0] hold_data_d;
  logic       hold_valid_q;
  logic       hold_valid_d;

  assign buf_empty      = !hold_valid_q;
  assign buf_full       = hold_valid_q;
  assign pop_data       = hold_data_q;
  assign level          = {{FifoDepthLog2{1'b0}}, hold_valid_q};
  assign buf_nonempty_d = hold_valid_d;

  // Push only happens when empty and pop only when full, so they never coincide
  always_comb begin
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;
    if (push) begin
      hold_data_d  = uart_in_data;
      hold_valid_d = 1'b1;
    end else if (pop) begin
      hold_valid_d = 1'b0;
    end else begin
      hold_valid_d = hold_valid_q;
    end
  end

  // Holding register; reset empties it
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      hold_data_q  <= 8'h00;
      hold_valid_q <= 1'b0;
    end else begin
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Frame state machine
  // ---------------------------------------------------------------------------
  state_e          state_q;
  state_e          state_d;
  logic [CntW-1:0] bit_cnt_q;
  logic [CntW-1:0] bit_cnt_d;
  logic [2:0]      bit_idx_q;
  logic [2:0]      bit_idx_d;
  logic [7:0]      shift_q;
  logic [7:0]      shift_d;
  logic            tx_q;
  logic            tx_d;
  logic            busy_q;
  logic            busy_d;
  logic            bit_last;

  assign bit_last = (bit_cnt_q == CntLast);

  // Next-state logic: each bit lasts Divisor cycles; pops happen from IDLE or
  // on the last stop-bit cycle so back-to-back frames have no idle gap
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!buf_empty) begin
          pop       = 1'b1;
          shift_d   = pop_data;
          bit_cnt_d = CntZero;
          state_d   = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_last) begin
          bit_cnt_d = CntZero;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + CntOne;
        end
      end
      DATA: begin
        if (bit_last) begin
          bit_cnt_d = CntZero;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CntOne;
        end
      end
      STOP: begin
        if (bit_last) begin
          bit_cnt_d = CntZero;
          if (!buf_empty) begin
            pop     = 1'b1;
            shift_d = pop_data;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CntOne;
        end
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = CntZero;
      end
    endcase
  end

  // Registered outputs are derived from the state being entered so pin_tx and
  // busy change on the same edge as the state
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE) || buf_nonempty_d;
  end

  // State, counters, shift register and output registers; reset abandons any
  // frame in flight and idles the line high
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= CntZero;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign pin_tx = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_stream.sv
// Testbench for uart_tx_stream. A serial receiver decodes pin_tx into bytes;
// a cycle model derives level/ready/busy from counts of accepted bytes and
// observed frame starts. Works for both buffer builds (UART_TX_FIFO_EN).
module tb_uart_tx_stream;

  localparam int CLK_HZ = 48000000;
  localparam int BAUD   = 12000000;
  localparam int FDL2   = 4;
  localparam int DIV    = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int FRAME  = 10 * DIV;
`ifdef UART_TX_FIFO_EN
  localparam int DEPTH = 16;
`else
  localparam int DEPTH = 1;
`endif

  logic          clk      = 1'b0;
  logic          reset    = 1'b1;
  logic [7:0]    in_data  = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          pin_tx;
  logic          busy;
  logic [FDL2:0] level;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // model state
  logic [7:0] exp_q[$];
  int         acc_q[$];
  int         pushes     = 0;
  int         starts     = 0;
  int         last_start = 0;
  int         max_level  = 0;

  // receiver output
  logic [7:0] rx_byte_q[$];
  bit         rx_ok_q[$];
  int         rx_start_q[$];

  uart_tx_stream #(
    .ClockHz      (CLK_HZ),
    .BaudRate     (BAUD),
    .FifoDepthLog2(FDL2)
  ) dut (
    .clk_48mhz    (clk),
    .reset        (reset),
    .uart_in_data (in_data),
    .uart_in_valid(in_valid),
    .uart_in_ready(in_ready),
    .pin_tx       (pin_tx),
    .busy         (busy),
    .level        (level)
  );

  always #5 clk = ~clk;

  // cycle counter: number of rising edges seen
  always @(posedge clk) cyc <= cyc + 1;

  // serial receiver: samples every cycle on the falling edge
  initial begin : rx_decoder
    bit              active;
    int              n;
    logic [FRAME-1:0] bits;
    logic [7:0]      b;
    bit              ok;
    active = 1'b0;
    n      = 0;
    bits   = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        active = 1'b0;
      end else if (!active) begin
        if (pin_tx === 1'b0) begin
          active     = 1'b1;
          bits       = '0;
          n          = 1;
          starts++;
          last_start = cyc;
        end
      end else begin
        bits[n] = pin_tx;
        n++;
        if (n == FRAME) begin
          ok = 1'b1;
          for (int k = 0; k < 10; k++)
            for (int j = 1; j < DIV; j++)
              if (bits[k*DIV+j] !== bits[k*DIV]) ok = 1'b0;
          if (bits[0] !== 1'b0 || bits[9*DIV] !== 1'b1) ok = 1'b0;
          for (int i = 0; i < 8; i++) b[i] = bits[(i+1)*DIV];
          rx_byte_q.push_back(b);
          rx_ok_q.push_back(ok);
          rx_start_q.push_back(last_start);
          active = 1'b0;
        end
      end
    end
  end

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Source: presents each byte, holds valid until accepted, scrambles data while
  // ready is low.
  task automatic send_bytes(input logic [7:0] bytes[$], input int gap_max);
    int waited;
    for (int i = 0; i < bytes.size(); i++) begin
      if (gap_max > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      end
      in_valid = 1'b1;
      waited   = 0;
      while (in_ready !== 1'b1 && waited < 400) begin
        in_data = 8'($urandom);
        @(negedge clk);
        waited++;
      end
      if (in_ready !== 1'b1) begin
        vectors++;
        miscompares++;
        $display("FAIL send_timeout: ready=%b after %0d cycles, required 1", in_ready, waited);
        in_valid = 1'b0;
        return;
      end
      in_data = bytes[i];
      @(posedge clk);
      pushes++;
      exp_q.push_back(bytes[i]);
      @(negedge clk);
      acc_q.push_back(cyc);
    end
    in_valid = 1'b0;
  endtask

  // Per-cycle model: level = accepted - started, ready = level < depth,
  // busy = frame on line or level > 0, line high outside frames.
  task automatic watch(input string name, input int ncyc);
    int lvl;
    bit in_frame;
    bit exp_ready;
    bit exp_busy;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      #2;
      lvl       = pushes - starts;
      in_frame  = (starts > 0) && ((cyc - last_start) < FRAME);
      exp_ready = (lvl < DEPTH);
      exp_busy  = in_frame || (lvl > 0);
      if (lvl > max_level) max_level = lvl;
      vectors++;
      if (level !== lvl[FDL2:0]) begin
        miscompares++;
        $display("FAIL %s_level: level=%0d required %0d at cycle %0d", name, level, lvl, cyc);
      end
      vectors++;
      if (in_ready !== exp_ready) begin
        miscompares++;
        $display("FAIL %s_ready: ready=%b required %b at cycle %0d", name, in_ready, exp_ready, cyc);
      end
      vectors++;
      if (busy !== exp_busy) begin
        miscompares++;
        $display("FAIL %s_busy: busy=%b required %b at cycle %0d", name, busy, exp_busy, cyc);
      end
      if (!in_frame) begin
        vectors++;
        if (pin_tx !== 1'b1) begin
          miscompares++;
          $display("FAIL %s_idle_pin: pin_tx=%b required 1 at cycle %0d", name, pin_tx, cyc);
        end
      end
    end
  endtask

  task automatic check_frames(input string name, input bit contiguous);
    logic [7:0] e;
    int         prev;
    int         i;
    prev = 0;
    i    = 0;
    vectors++;
    if (rx_byte_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL %s_frame_count: received %0d frames, required %0d", name, rx_byte_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && rx_byte_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (rx_byte_q[0] !== e) begin
        miscompares++;
        $display("FAIL %s_byte%0d: received 0x%02h required 0x%02h", name, i, rx_byte_q[0], e);
      end
      vectors++;
      if (rx_ok_q[0] !== 1'b1) begin
        miscompares++;
        $display("FAIL %s_shape%0d: frame shape ok=%b required 1", name, i, rx_ok_q[0]);
      end
      if (contiguous && i > 0) begin
        vectors++;
        if (rx_start_q[0] - prev != FRAME) begin
          miscompares++;
          $display("FAIL %s_gap%0d: frame spacing %0d cycles required %0d", name, i, rx_start_q[0] - prev, FRAME);
        end
      end
      prev = rx_start_q[0];
      void'(rx_byte_q.pop_front());
      void'(rx_ok_q.pop_front());
      void'(rx_start_q.pop_front());
      i++;
    end
    exp_q.delete();
    rx_byte_q.delete();
    rx_ok_q.delete();
    rx_start_q.delete();
    acc_q.delete();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: ready=%b required 0", in_ready); end
    vectors++;
    if (pin_tx !== 1'b1) begin miscompares++; $display("FAIL reset_pin: pin_tx=%b required 1", pin_tx); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: busy=%b required 0", busy); end
    vectors++;
    if (level !== 5'd0) begin miscompares++; $display("FAIL reset_level: level=%0d required 0", level); end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL release_ready: ready=%b required 1", in_ready); end
    watch("idle", 100);
  endtask

  task automatic test_single_byte;
    logic [7:0] q[$];
    q.push_back(8'h55);
    fork
      send_bytes(q, 0);
      watch("single", FRAME + 20);
    join
    vectors++;
    if (rx_start_q.size() == 0 || acc_q.size() == 0) begin
      miscompares++;
      $display("FAIL single_latency: frames=%0d accepts=%0d, required 1 each", rx_start_q.size(), acc_q.size());
    end else if (rx_start_q[0] != acc_q[0] + 1) begin
      miscompares++;
      $display("FAIL single_latency: start at cycle %0d required %0d", rx_start_q[0], acc_q[0] + 1);
    end
    check_frames("single", 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [7:0] q[$];
    q.push_back(8'h00);
    q.push_back(8'hFF);
    q.push_back(8'hA5);
    fork
      send_bytes(q, 0);
      watch("b2b", 3 * FRAME + 60);
    join
    check_frames("b2b", 1'b1);
  endtask

  task automatic test_hold_valid;
    logic [7:0] q[$];
    int         n;
    n = DEPTH + 4;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    max_level = 0;
    fork
      send_bytes(q, 0);
      watch("hold", n * FRAME + 60);
    join
    vectors++;
    if (max_level != DEPTH) begin
      miscompares++;
      $display("FAIL hold_full_level: peak level %0d required %0d", max_level, DEPTH);
    end
    check_frames("hold", 1'b1);
  endtask

  task automatic test_random;
    logic [7:0] q[$];
    for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
    fork
      send_bytes(q, 70);
      watch("random", 1300);
    join
    check_frames("random", 1'b0);
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] q[$];
    logic [7:0] q2[$];
    q.push_back(8'h3C);
    send_bytes(q, 0);
    for (int c = 0; c < 10 && starts == 0; c++) @(negedge clk);
    repeat (2 * DIV + 1) @(negedge clk);
    #3 reset = 1'b1;
    #1;
    vectors++;
    if (pin_tx !== 1'b1) begin miscompares++; $display("FAIL midreset_pin: pin_tx=%b required 1", pin_tx); end
    vectors++;
    if (level !== 5'd0) begin miscompares++; $display("FAIL midreset_level: level=%0d required 0", level); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: busy=%b required 0", busy); end
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL midreset_ready: ready=%b required 0", in_ready); end
    exp_q.delete();
    rx_byte_q.delete();
    rx_ok_q.delete();
    rx_start_q.delete();
    acc_q.delete();
    pushes = 0;
    starts = 0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (pin_tx !== 1'b1) begin miscompares++; $display("FAIL midreset_hold_pin: pin_tx=%b required 1", pin_tx); end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midreset_release_ready: ready=%b required 1", in_ready); end
    q2.push_back(8'h81);
    fork
      send_bytes(q2, 0);
      watch("after_reset", FRAME + 20);
    join
    check_frames("after_reset", 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_hold_valid();
    test_random();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
